// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and its memory.
// Signal suffixes are from the fetch unit's point of view.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_data_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, one-entry skid buffer for IF_ID stalls,
// and branch redirect that lets an in-flight memory request drain before refetching.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          branch_i,
  input  logic [31:0]   branch_target_i,
  fetch_unit_if.master  imem,
  output logic [31:0]   PC_o,
  output logic [31:0]   instruction_o,
  output logic          valid_o,
  output logic          flush_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] drop_addr_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_inst_q;
  logic [31:0] pc_out_q;
  logic [31:0] inst_out_q;
  logic        valid_q;

  logic [31:0] pc_inc_d;
  logic [31:0] target_d;
  logic        ready_d;

  assign pc_inc_d = pc_q + 32'd4;
  assign target_d = branch_target_i & ~32'h0000_0003;
  assign ready_d  = imem.imem_ready_i;

  // DROP keeps presenting the abandoned address so the memory handshake stays legal.
  assign imem.imem_req_o  = ~rst_i & (state_q != HOLD);
  assign imem.imem_addr_o = (state_q == DROP) ? drop_addr_q : pc_q;
  assign flush_o          = branch_i & ~rst_i;

  assign PC_o          = pc_out_q;
  assign instruction_o = inst_out_q;
  assign valid_o       = valid_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= 32'h0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
      pc_out_q    <= 32'h0;
      inst_out_q  <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (branch_i) begin
            pc_q    <= target_d;
            valid_q <= 1'b0;
            if (!ready_d) begin
              drop_addr_q <= pc_q;
              state_q     <= DROP;
            end
          end else if (ready_d) begin
            pc_q <= pc_inc_d;
            if (stall_i) begin
              skid_pc_q   <= pc_q;
              skid_inst_q <= imem.imem_data_i;
              state_q     <= HOLD;
            end else begin
              pc_out_q   <= pc_q;
              inst_out_q <= imem.imem_data_i;
              valid_q    <= 1'b1;
            end
          end else if (!stall_i) begin
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (branch_i) begin
            pc_q        <= target_d;
            valid_q     <= 1'b0;
            skid_pc_q   <= 32'h0;
            skid_inst_q <= 32'h0;
            state_q     <= FETCH;
          end else if (!stall_i) begin
            pc_out_q   <= skid_pc_q;
            inst_out_q <= skid_inst_q;
            valid_q    <= 1'b1;
            state_q    <= FETCH;
          end
        end
        DROP: begin
          // The late response belongs to the squashed path; only the redirect survives.
          if (branch_i) begin
            pc_q    <= target_d;
            valid_q <= 1'b0;
          end
          if (ready_d) begin
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_i  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 stall_i  input  1  downstream (IF_ID) hold; delivered outputs frozen while high.
REQ-005 branch_i  input  1  redirect request from later stage, one-cycle pulse.
REQ-006 branch_target_i  input  32  redirect address.
REQ-007 imem_req_o  output  1  instruction-memory request valid.
REQ-008 imem_addr_o  output  32  instruction-memory word address.
REQ-009 imem_ready_i  input  1  memory response valid for current request, latency >= 0 cycles.
REQ-010 imem_data_i  input  32  instruction word, valid when imem_ready_i=1.
REQ-011 PC_o  output  32  PC of delivered instruction, feeds IF_ID PC_i.
REQ-012 instruction_o  output  32  delivered instruction, feeds IF_ID instruction_i.
REQ-013 valid_o  output  1  PC_o/instruction_o hold a live instruction.
REQ-014 flush_o  output  1  feeds IF_ID IF_flush.

Function
REQ-015 States SHALL be FETCH, HOLD, DROP; internal regs pc_q (32), skid_pc/skid_inst (32 each).
REQ-016 FETCH: imem_req_o=1, imem_addr_o=pc_q.
REQ-017 Handshake: once imem_req_o=1, imem_addr_o SHALL stay stable until the cycle imem_ready_i=1; a response completes only in a cycle with req=1 and ready=1.
REQ-018 FETCH, ready=1, stall_i=0: PC_o<=pc_q, instruction_o<=imem_data_i, valid_o<=1, pc_q<=pc_q+4; stay FETCH; back-to-back completions give one instruction per cycle.
REQ-019 FETCH, ready=1, stall_i=1: skid_pc<=pc_q, skid_inst<=imem_data_i, pc_q<=pc_q+4, go HOLD; outputs unchanged.
REQ-020 HOLD: imem_req_o=0; while stall_i=1 outputs and skid frozen; first cycle stall_i=0: outputs<=skid contents, valid_o<=1, go FETCH.
REQ-021 FETCH, ready=0, stall_i=0: valid_o<=0 (bubble); stall_i=1: outputs unchanged.
REQ-022 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-023 branch_i=1 (priority over stall_i and all completions): pc_q<=branch_target_i with bits[1:0] forced to 0, valid_o<=0, skid discarded, flush_o=1 same cycle.
REQ-024 flush_o SHALL be combinational branch_i & ~rst_i; no other source.
REQ-025 branch_i in FETCH with req=1, ready=0: go DROP; imem_addr_o keeps old address.
REQ-026 DROP: imem_req_o=1 at old address; on ready=1 data discarded, go FETCH at new pc_q; further branch_i in DROP updates pc_q only.
REQ-027 branch_i in same cycle as ready=1 (FETCH): response discarded, go FETCH at target next cycle.
REQ-028 branch_i in HOLD: skid discarded, go FETCH at target.
REQ-029 Outputs SHALL be registered except flush_o, imem_req_o, imem_addr_o (state-decoded).

Reset
REQ-030 rst_i=1: state<=FETCH, pc_q<=RESET_PC, PC_o<=0, instruction_o<=0, valid_o<=0, skid<=0; imem_req_o=0 and flush_o=0 during reset cycles.
REQ-031 Reset SHALL override all inputs, including mid-DROP/HOLD; outstanding request abandoned, memory treats req drop as abort.
REQ-032 First request SHALL issue in first cycle after rst_i deasserts, addr=RESET_PC.

Verification
REQ-033 Reset release, ready tied 1 -> addr 0,4,8; PC_o 0,4,8 one cycle after each; valid_o=1 from cycle 2.
REQ-034 stall_i=1 for 3 cycles while ready=1 -> one skid capture, req low in HOLD, PC_o frozen, no instruction lost or duplicated after release.
REQ-035 branch_i with target 32'h0000_0103 -> flush_o=1 same cycle, next addr 32'h0000_0100, valid_o=0 one cycle.
REQ-036 branch_i while request to 0x40 pending (ready late by 2) -> addr 0x40 held until ready, data discarded, then fetch target.
REQ-037 RESET_PC=32'hFFFF_FFF8, ready=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst_i asserted in DROP -> next cycle req=0, valid_o=0, then fetch from RESET_PC.
